// File: rtl/spike_time_mux_if.sv
// spike_time_mux_if: network-side and column-side signals of the spike time multiplexer.
interface spike_time_mux_if #(
  parameter int P = 64,
  parameter int Q = 2,
  parameter int N_NET = 2,
  parameter int SLOT_LEN = 18,
  parameter int NW = (N_NET > 1) ? $clog2(N_NET) : 1,
  parameter int TW = $clog2(SLOT_LEN + 1)
);
  logic gamma_start;
  logic [N_NET*P-1:0] data_in;
  logic [N_NET-1:0] net_en;
  logic [P-1:0] col_spikes_in;
  logic col_grst;
  logic [NW-1:0] col_net_idx;
  logic [Q-1:0] col_spikes_out;
  logic [N_NET*Q-1:0] out_spikes;
  logic [N_NET*Q*TW-1:0] out_time;
  logic out_valid;
  logic sync_err;
  modport master (
    output gamma_start, data_in, net_en, col_spikes_out,
    input col_spikes_in, col_grst, col_net_idx, out_spikes, out_time, out_valid, sync_err
  );
  modport slave (
    input gamma_start, data_in, net_en, col_spikes_out,
    output col_spikes_in, col_grst, col_net_idx, out_spikes, out_time, out_valid, sync_err
  );
endinterface

// File: rtl/spike_time_mux.sv
// spike_time_mux: captures N_NET spike waves per gamma cycle and replays them one sub-slot each through a shared column.
module spike_time_mux #(
  parameter int P = 64,
  parameter int Q = 2,
  parameter int N_NET = 2,
  parameter int SLOT_LEN = 18,
  parameter int COL_LAT = 1
) (
  input logic clk,
  input logic rstb,
  spike_time_mux_if.slave bus
);
  localparam int NW = (N_NET > 1) ? $clog2(N_NET) : 1;
  localparam int OW = $clog2(SLOT_LEN);
  localparam int TW = $clog2(SLOT_LEN + 1);
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  typedef struct packed {
    logic act;
    logic en;
    logic [NW-1:0] net;
    logic [OW-1:0] off;
  } tag_t;
  state_t state_q, state_d;
  logic [NW-1:0] net_q, net_d, col_idx_q, col_idx_d;
  logic [OW-1:0] off_q, off_d;
  logic bank_q, bank_d, sync_err_q, sync_err_d;
  logic col_grst_q, col_grst_d, out_valid_q, out_valid_d;
  logic [N_NET-1:0] en_q, en_d;
  logic [P-1:0] mem_q [2][N_NET][SLOT_LEN];
  logic [P-1:0] mem_d [2][N_NET][SLOT_LEN];
  logic [P-1:0] col_in_q, col_in_d;
  tag_t tag_q [COL_LAT+1];
  tag_t tag_d [COL_LAT+1];
  tag_t tl;
  logic [N_NET*Q-1:0] fired_q, fired_d, out_spikes_q, out_spikes_d;
  logic [N_NET*Q*TW-1:0] time_q, time_d, out_time_q, out_time_d;
  logic wrap, abort, replay, pub, hit;
  int idx;
  always_comb begin
    wrap = net_q == NW'(N_NET - 1) && off_q == OW'(SLOT_LEN - 1);
    abort = state_q != IDLE && bus.gamma_start && !wrap;
    replay = state_q == RUN && !abort;
    state_d = state_q;
    net_d = net_q;
    off_d = off_q;
    bank_d = bank_q;
    en_d = en_q;
    sync_err_d = sync_err_q || abort;
    mem_d = mem_q;
    if (state_q == IDLE) state_d = bus.gamma_start ? FILL : IDLE;
    else if (abort) begin
      state_d = FILL;
      net_d = '0;
      off_d = '0;
    end else begin
      off_d = off_q == OW'(SLOT_LEN - 1) ? '0 : off_q + OW'(1);
      net_d = wrap ? '0 : net_q + NW'(off_q == OW'(SLOT_LEN - 1));
      if (wrap) begin
        state_d = RUN;
        bank_d = ~bank_q;
        en_d = bus.net_en;
      end
    end
    // every network is captured in the first sub-slot; the rest of the cycle is replay-only
    if (state_q != IDLE && net_q == '0)
      for (int n = 0; n < N_NET; n++) mem_d[bank_q][n][off_q] = bus.data_in[n*P +: P];
    col_in_d = replay && en_q[net_q] ? mem_q[~bank_q][net_q][off_q] : '0;
    col_grst_d = replay && off_q == '0;
    col_idx_d = replay ? net_q : '0;
    tag_d = tag_q;
    tag_d[0] = {replay, en_q[net_q], net_q, off_q};
    for (int k = 1; k <= COL_LAT; k++) tag_d[k] = tag_q[k-1];
    if (abort) for (int k = 0; k <= COL_LAT; k++) tag_d[k].act = 1'b0;
    // tl is the (net, offset) that produced the column output seen this clock
    tl = tag_q[COL_LAT];
    fired_d = fired_q;
    time_d = time_q;
    hit = 1'b0;
    idx = 0;
    pub = tl.act && !abort && tl.net == NW'(N_NET - 1) && tl.off == OW'(SLOT_LEN - 1);
    if (tl.act && !abort)
      for (int q = 0; q < Q; q++) begin
        idx = int'(tl.net) * Q + q;
        hit = tl.en && bus.col_spikes_out[q];
        if (tl.off == '0 || (hit && !fired_q[idx])) begin
          fired_d[idx] = hit;
          time_d[idx*TW +: TW] = hit ? TW'(tl.off) : TW'(SLOT_LEN);
        end
      end
    out_valid_d = pub;
    out_spikes_d = pub ? fired_d : out_spikes_q;
    out_time_d = pub ? time_d : out_time_q;
  end
  always_ff @(posedge clk or posedge rstb)
    if (rstb) begin
      state_q <= IDLE;
      net_q <= '0;
      off_q <= '0;
      bank_q <= 1'b0;
      en_q <= '0;
      sync_err_q <= 1'b0;
      mem_q <= '{default: '0};
      col_in_q <= '0;
      col_grst_q <= 1'b0;
      col_idx_q <= '0;
      tag_q <= '{default: '0};
      fired_q <= '0;
      time_q <= '0;
      out_valid_q <= 1'b0;
      out_spikes_q <= '0;
      out_time_q <= '0;
    end else begin
      state_q <= state_d;
      net_q <= net_d;
      off_q <= off_d;
      bank_q <= bank_d;
      en_q <= en_d;
      sync_err_q <= sync_err_d;
      mem_q <= mem_d;
      col_in_q <= col_in_d;
      col_grst_q <= col_grst_d;
      col_idx_q <= col_idx_d;
      tag_q <= tag_d;
      fired_q <= fired_d;
      time_q <= time_d;
      out_valid_q <= out_valid_d;
      out_spikes_q <= out_spikes_d;
      out_time_q <= out_time_d;
    end
  assign bus.col_spikes_in = col_in_q;
  assign bus.col_grst = col_grst_q;
  assign bus.col_net_idx = col_idx_q;
  assign bus.out_spikes = out_spikes_q;
  assign bus.out_time = out_time_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sync_err = sync_err_q;
endmodule

// File: tb/tb_spike_time_mux.sv
// tb_spike_time_mux: directed capture/replay/demux vectors with a one-clock column model.
module tb_spike_time_mux;
  localparam int P = 64, Q = 2, NN = 2, SL = 18, CL = 1, E = NN * SL, TW = $clog2(SL + 1);
  localparam logic [SL-1:0] A0 = 18'(1) << 5, A1 = 18'(1) << 2, B0 = (18'(1) << 4) | (18'(1) << 9);
  localparam logic [19:0] T2 = {5'd2, 5'd18, 5'd18, 5'd5};
  localparam logic [19:0] T3 = {5'd2, 5'd18, 5'd18, 5'd18};
  localparam logic [19:0] T4 = {5'd2, 5'd18, 5'd18, 5'd4};
  logic clk = 1'b0, rstb = 1'b1;
  logic [Q-1:0] col_q;
  int checks = 0, errors = 0;
  logic run = 1'b0, se = 1'b0;
  logic [SL-1:0] cap0 = '0, cap1 = '0;
  logic [1:0] en_m = '0;
  spike_time_mux_if #(.P(P), .Q(Q), .N_NET(NN), .SLOT_LEN(SL)) bus ();
  spike_time_mux #(.P(P), .Q(Q), .N_NET(NN), .SLOT_LEN(SL), .COL_LAT(CL)) dut (
    .clk(clk), .rstb(rstb), .bus(bus)
  );
  always #5 clk = ~clk;
  // column: neuron0 answers input bit3, neuron1 answers bit7, one clock later
  always @(posedge clk) col_q <= {bus.col_spikes_in[7], bus.col_spikes_in[3]};
  assign bus.col_spikes_out = col_q;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_col_in"}, bus.col_spikes_in, 0);
    check({tag, "_grst"}, bus.col_grst, 0);
    check({tag, "_idx"}, bus.col_net_idx, 0);
    check({tag, "_spikes"}, bus.out_spikes, 0);
    check({tag, "_time"}, bus.out_time, 0);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_sync"}, bus.sync_err, 0);
  endtask
  task automatic start();
    @(negedge clk);
    bus.gamma_start = 1'b1;
  endtask
  task automatic run_cycle(input logic [SL-1:0] m0, input logic [SL-1:0] m1, input logic [1:0] en,
                           input int len, input logic gs_last, input logic ev,
                           input logic [3:0] es, input logic [19:0] et);
    logic [E-1:0] g, s3, s7, ix, ov, lm, eg, e3, e7, eix;
    logic [3:0] spk;
    logic [19:0] tm;
    g = '0; s3 = '0; s7 = '0; ix = '0; ov = '0; lm = '0; spk = '0; tm = '0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      g[c] = bus.col_grst;
      s3[c] = bus.col_spikes_in[3];
      s7[c] = bus.col_spikes_in[7];
      ix[c] = bus.col_net_idx[0];
      ov[c] = bus.out_valid;
      lm[c] = 1'b1;
      if (bus.out_valid) begin
        spk = bus.out_spikes;
        tm = bus.out_time;
      end
      if (c < SL) begin
        bus.data_in = '0;
        bus.data_in[3] = m0[c];
        bus.data_in[P+7] = m1[c];
      end else bus.data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.net_en = en;
      bus.gamma_start = gs_last && (c == len - 1);
    end
    eg = '0; e3 = '0; e7 = '0; eix = '0;
    if (run) begin
      eg[1] = 1'b1;
      eg[SL+1] = 1'b1;
      if (en_m[0]) e3 = E'(cap0) << 1;
      if (en_m[1]) e7 = E'(cap1) << (SL + 1);
      for (int c = SL + 1; c < E; c++) eix[c] = 1'b1;
    end
    check("col_grst", g & lm, eg & lm);
    check("col_bit3", s3 & lm, e3 & lm);
    check("col_bit7", s7 & lm, e7 & lm);
    check("col_idx", (ix & lm) >> 1, (eix & lm) >> 1);
    check("out_valid", ov & lm, ev ? (E'(1) << 2) : '0);
    if (ev) begin
      check("out_spikes", spk, es);
      check("out_time", tm, et);
      check("hold_spikes", bus.out_spikes, es);
    end
    check("sync_err", bus.sync_err, se);
    if (len == E) begin
      run = 1'b1;
      cap0 = m0;
      cap1 = m1;
      en_m = en;
    end else if (gs_last) begin
      run = 1'b0;
      se = 1'b1;
    end
  endtask
  initial begin
    logic any;
    bus.gamma_start = 1'b0;
    bus.data_in = '0;
    bus.net_en = '1;
    repeat (3) @(negedge clk);
    check_zero("rst");
    rstb = 1'b0;
    any = 1'b0;
    repeat (100) begin
      @(negedge clk);
      any |= bus.col_grst | (|bus.col_spikes_in) | bus.out_valid | (|bus.out_spikes) |
             (|bus.out_time) | bus.sync_err | (|bus.col_net_idx);
    end
    check("idle_quiet", any, 0);
    start();
    run_cycle(A0, A1, 2'b11, E, 1'b1, 1'b0, 4'b0, 20'b0);
    run_cycle(A0, A1, 2'b10, E, 1'b0, 1'b0, 4'b0, 20'b0);
    run_cycle(B0, A1, 2'b11, E, 1'b1, 1'b1, 4'b1001, T2);
    run_cycle(A0, A1, 2'b11, E, 1'b1, 1'b1, 4'b1000, T3);
    run_cycle(A0, A1, 2'b11, 21, 1'b1, 1'b1, 4'b1001, T4);
    run_cycle(A0, A1, 2'b11, E, 1'b1, 1'b0, 4'b0, 20'b0);
    run_cycle(A0, A1, 2'b11, E, 1'b1, 1'b0, 4'b0, 20'b0);
    run_cycle(A0, A1, 2'b11, E, 1'b1, 1'b1, 4'b1001, T2);
    run_cycle(A0, A1, 2'b11, 25, 1'b0, 1'b1, 4'b1001, T2);
    @(negedge clk);
    rstb = 1'b1;
    #1;
    check_zero("async_rst");
    run = 1'b0;
    se = 1'b0;
    @(negedge clk);
    rstb = 1'b0;
    start();
    run_cycle(A0, A1, 2'b11, E, 1'b1, 1'b0, 4'b0, 20'b0);
    run_cycle(A0, A1, 2'b11, E, 1'b1, 1'b0, 4'b0, 20'b0);
    run_cycle(A0, A1, 2'b11, E, 1'b1, 1'b1, 4'b1001, T2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
